// File: rtl/exp_sched_pkg.sv
// Shared constants for the exp scheduler: operand/result width and the
// largest requester count the tag logic is sized for.
package exp_sched_pkg;
  localparam int EXP_DATA_W = 32;
  localparam int N_REQ_MAX  = 8;
endpackage

// File: rtl/exp_sched_if.sv
// Bundle of the requester, response and exp-unit streams around exp_sched.
// Every stream is AXI-stream style: a beat transfers on a clock edge where
// tvalid and tready are both 1; a source holds tdata/tvalid until taken.
interface exp_sched_if
  import exp_sched_pkg::*;
#(
  parameter int N_REQ = 4
);
  logic [EXP_DATA_W*N_REQ-1:0] s_req_tdata;
  logic [N_REQ-1:0]            s_req_tvalid;
  logic [N_REQ-1:0]            s_req_tready;
  logic [EXP_DATA_W*N_REQ-1:0] m_rsp_tdata;
  logic [N_REQ-1:0]            m_rsp_tvalid;
  logic [N_REQ-1:0]            m_rsp_tready;
  logic [EXP_DATA_W-1:0]       m_exp_tdata;
  logic                        m_exp_tvalid;
  logic                        m_exp_tready;
  logic [EXP_DATA_W-1:0]       s_exp_tdata;
  logic                        s_exp_tvalid;
  logic                        s_exp_tready;

  modport master (
    input  s_req_tdata, s_req_tvalid, m_rsp_tready, m_exp_tready, s_exp_tdata, s_exp_tvalid,
    output s_req_tready, m_rsp_tdata, m_rsp_tvalid, m_exp_tdata, m_exp_tvalid, s_exp_tready
  );

  modport slave (
    output s_req_tdata, s_req_tvalid, m_rsp_tready, m_exp_tready, s_exp_tdata, s_exp_tvalid,
    input  s_req_tready, m_rsp_tdata, m_rsp_tvalid, m_exp_tdata, m_exp_tvalid, s_exp_tready
  );
endinterface

// File: rtl/exp_sched_tag_fifo.sv
// In-order FIFO of requester tags for operands currently inside the exp unit.
// Push and pop may happen in the same cycle; pop_data shows the head entry.
module exp_sched_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         empty,
  output logic         full,
  output logic [W:0]   count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  assign empty    = (count == '0);
  assign full     = (count == (W+1)'(DEPTH));
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Credits cap the tags in flight below DEPTH, so a push never meets a full FIFO.
  assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));
endmodule

// File: rtl/exp_sched.sv
// Round-robin sharing of one exp pipeline among N_REQ requesters, with one
// credit per requester and an in-order tag FIFO to route results back.
module exp_sched
  import exp_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int TAG_W = 3
) (
  input  logic             aclk,
  input  logic             aresetn,
  exp_sched_if.master      bus,
  output logic             err_orphan,
  output logic [TAG_W:0]   inflight,
  output logic [TAG_W-1:0] dbg_last_grant
);
  logic [N_REQ-1:0]                 credit_busy;
  logic [N_REQ-1:0]                 grant;
  logic                             grant_valid;
  logic [TAG_W-1:0]                 grant_idx;
  logic [EXP_DATA_W-1:0]            grant_data;
  logic [TAG_W-1:0]                 last_grant;
  logic                             issue_valid;
  logic [EXP_DATA_W-1:0]            issue_data;
  logic [N_REQ-1:0][EXP_DATA_W-1:0] rsp_data;
  logic [N_REQ-1:0]                 rsp_valid;
  logic                             exp_rdy;
  logic                             can_issue;
  logic                             ret_hs;
  logic                             ret_pop;
  logic [TAG_W-1:0]                 ret_tag;
  logic                             fifo_empty;
  logic                             fifo_full;

  assign can_issue = !issue_valid || bus.m_exp_tready;
  assign ret_hs    = bus.s_exp_tvalid && exp_rdy;
  assign ret_pop   = ret_hs && !fifo_empty;

  // Search from last_grant+1 with wrap; the first eligible requester wins.
  always_comb begin
    int idx;
    idx         = 0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last_grant) + k) % N_REQ;
      for (int i = 0; i < N_REQ; i++) begin
        if (i == idx && !grant_valid && aresetn && can_issue &&
            bus.s_req_tvalid[i] && !credit_busy[i]) begin
          grant_valid = 1'b1;
          grant_idx   = TAG_W'(i);
        end
      end
    end
    grant = grant_valid ? (N_REQ'(1) << grant_idx) : '0;
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < N_REQ; i++)
      if (grant[i]) grant_data = bus.s_req_tdata[EXP_DATA_W*i +: EXP_DATA_W];
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      credit_busy <= '0;
      last_grant  <= TAG_W'(N_REQ-1);
      issue_valid <= 1'b0;
      issue_data  <= '0;
      rsp_data    <= '0;
      rsp_valid   <= '0;
      err_orphan  <= 1'b0;
      exp_rdy     <= 1'b0;
    end else begin
      exp_rdy <= 1'b1;
      if (issue_valid && bus.m_exp_tready) issue_valid <= 1'b0;
      if (grant_valid) begin
        issue_valid <= 1'b1;
        issue_data  <= grant_data;
        last_grant  <= grant_idx;
      end
      if (ret_hs && fifo_empty) err_orphan <= 1'b1;
      for (int i = 0; i < N_REQ; i++) begin
        if (rsp_valid[i] && bus.m_rsp_tready[i]) begin
          rsp_valid[i]   <= 1'b0;
          credit_busy[i] <= 1'b0;
        end
        if (ret_pop && ret_tag == TAG_W'(i)) begin
          rsp_valid[i] <= 1'b1;
          rsp_data[i]  <= bus.s_exp_tdata;
        end
        if (grant[i]) credit_busy[i] <= 1'b1;
      end
    end
  end

  exp_sched_tag_fifo #(
    .DEPTH (N_REQ),
    .W     (TAG_W)
  ) u_tag_fifo (
    .clk       (aclk),
    .rst_n     (aresetn),
    .push      (grant_valid),
    .push_data (grant_idx),
    .pop       (ret_pop),
    .pop_data  (ret_tag),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (inflight)
  );

  assign bus.s_req_tready = grant;
  assign bus.m_rsp_tdata  = rsp_data;
  assign bus.m_rsp_tvalid = rsp_valid;
  assign bus.m_exp_tdata  = issue_data;
  assign bus.m_exp_tvalid = issue_valid;
  assign bus.s_exp_tready = exp_rdy;
  assign dbg_last_grant   = last_grant;
endmodule

// File: tb/tb_exp_sched.sv
// Directed bench for exp_sched with a latency-3 exp model fed 3.12 operands.
module tb_exp_sched;
  localparam int N  = 4;
  localparam int TW = 3;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  exp_sched_if #(.N_REQ(N)) bus ();
  logic          err_orphan;
  logic [TW:0]   inflight;
  logic [TW-1:0] dbg_last_grant;

  exp_sched #(.N_REQ(N), .TAG_W(TW)) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .bus            (bus),
    .err_orphan     (err_orphan),
    .inflight       (inflight),
    .dbg_last_grant (dbg_last_grant)
  );

  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] exp_fn(input logic [31:0] x);
    real r;
    r = $exp($itor($signed(x[15:0])) / 4096.0) * 4096.0;
    return 32'($rtoi(r));
  endfunction

  // exp model: latency 3, always ready unless exp_ready is pulled low
  logic        exp_ready    = 1'b0;
  logic        orphan_pulse = 1'b0;
  logic [2:0]  v_pipe;
  logic [31:0] d0, d1, d2;
  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      v_pipe <= '0; d0 <= '0; d1 <= '0; d2 <= '0;
    end else begin
      v_pipe <= {v_pipe[1:0], bus.m_exp_tvalid && exp_ready};
      d0 <= exp_fn(bus.m_exp_tdata);
      d1 <= d0;
      d2 <= d1;
    end
  end
  assign bus.m_exp_tready = exp_ready;
  assign bus.s_exp_tvalid = v_pipe[2] | orphan_pulse;
  assign bus.s_exp_tdata  = orphan_pulse ? 32'h0000_dead : d2;

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    bus.s_req_tdata  = '0;
    bus.s_req_tvalid = 4'hf;
    bus.m_rsp_tready = '0;
    repeat (2) step();
    total++; if (bus.s_req_tready !== 4'h0) begin bad++; $display("FAIL reset_req_tready got=%h exp=0", bus.s_req_tready); end
    total++; if (bus.m_rsp_tvalid !== 4'h0) begin bad++; $display("FAIL reset_rsp_tvalid got=%h exp=0", bus.m_rsp_tvalid); end
    total++; if (bus.m_exp_tvalid !== 1'b0) begin bad++; $display("FAIL reset_exp_tvalid got=%b exp=0", bus.m_exp_tvalid); end
    total++; if (bus.s_exp_tready !== 1'b0) begin bad++; $display("FAIL reset_exp_tready got=%b exp=0", bus.s_exp_tready); end
    total++; if (err_orphan !== 1'b0) begin bad++; $display("FAIL reset_err_orphan got=%b exp=0", err_orphan); end
    total++; if (inflight !== 4'd0) begin bad++; $display("FAIL reset_inflight got=%0d exp=0", inflight); end
    total++; if (dbg_last_grant !== 3'd3) begin bad++; $display("FAIL reset_last_grant got=%0d exp=3", dbg_last_grant); end
    bus.s_req_tvalid = '0;
    aresetn = 1'b1;
    step();
    total++; if (bus.s_exp_tready !== 1'b1) begin bad++; $display("FAIL post_reset_exp_tready got=%b exp=1", bus.s_exp_tready); end
  endtask

  task automatic test_round_robin();
    logic [31:0] ops [4];
    logic [3:0]  e;
    int          exp_q [$];
    int          id;
    ops[0] = 32'h0000_0000; ops[1] = 32'h0000_1000;
    ops[2] = 32'h0000_2000; ops[3] = 32'h0000_f000;
    exp_ready        = 1'b1;
    bus.m_rsp_tready = 4'hf;
    for (int k = 0; k < 4; k++) bus.s_req_tdata[32*k +: 32] = ops[k];
    bus.s_req_tvalid = 4'hf;
    for (int k = 0; k < 4; k++) begin
      e = 4'b0001 << k;
      #1;
      total++; if (bus.s_req_tready !== e) begin bad++; $display("FAIL rr_grant%0d got=%b exp=%b", k, bus.s_req_tready, e); end
      step();
      bus.s_req_tvalid[k] = 1'b0;
      total++; if (bus.m_exp_tdata !== ops[k] || bus.m_exp_tvalid !== 1'b1)
        begin bad++; $display("FAIL rr_issue%0d got=%h exp=%h", k, bus.m_exp_tdata, ops[k]); end
    end
    exp_q = {0, 1, 2, 3};
    for (int n = 0; n < 20 && exp_q.size() > 0; n++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (bus.m_rsp_tvalid[i] && exp_q.size() > 0) begin
          id = exp_q.pop_front();
          total++; if (i != id || bus.m_rsp_tdata[32*i +: 32] !== exp_fn(ops[i]))
            begin bad++; $display("FAIL rr_rsp port=%0d exp_port=%0d got=%h exp=%h", i, id, bus.m_rsp_tdata[32*i +: 32], exp_fn(ops[i])); end
        end
      end
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rr_rsp_timeout missing=%0d exp=0", exp_q.size()); end
    repeat (2) step();
  endtask

  task automatic test_single();
    int n;
    bus.s_req_tdata[31:0] = 32'h0;
    bus.s_req_tvalid      = 4'b0001;
    #1;
    total++; if (bus.s_req_tready !== 4'b0001) begin bad++; $display("FAIL single_grant got=%b exp=0001", bus.s_req_tready); end
    step();
    bus.s_req_tvalid = '0;
    total++; if (bus.m_exp_tvalid !== 1'b1 || inflight !== 4'd1)
      begin bad++; $display("FAIL single_issue tvalid=%b inflight=%0d exp=1/1", bus.m_exp_tvalid, inflight); end
    n = 1;
    while (!bus.m_rsp_tvalid[0] && n < 12) begin step(); n++; end
    total++; if (n != 5) begin bad++; $display("FAIL single_latency got=%0d exp=5", n); end
    total++; if (bus.m_rsp_tdata[31:0] !== 32'h1000) begin bad++; $display("FAIL single_data got=%h exp=00001000", bus.m_rsp_tdata[31:0]); end
    total++; if (inflight !== 4'd0) begin bad++; $display("FAIL single_inflight got=%0d exp=0", inflight); end
    repeat (2) step();
  endtask

  task automatic test_credit_stall();
    int  n;
    bit  seen1;
    bus.m_rsp_tready = 4'b1011;
    bus.s_req_tdata[64 +: 32] = 32'h0000_1000;
    bus.s_req_tvalid = 4'b0100;
    #1;
    total++; if (bus.s_req_tready !== 4'b0100) begin bad++; $display("FAIL stall_first_grant got=%b exp=0100", bus.s_req_tready); end
    step();
    bus.s_req_tvalid = '0;
    n = 0;
    while (!bus.m_rsp_tvalid[2] && n < 12) begin step(); n++; end
    total++; if (bus.m_rsp_tvalid[2] !== 1'b1 || bus.m_rsp_tdata[64 +: 32] !== exp_fn(32'h1000))
      begin bad++; $display("FAIL stall_first_rsp got=%h exp=%h", bus.m_rsp_tdata[64 +: 32], exp_fn(32'h1000)); end
    bus.s_req_tdata[64 +: 32] = 32'h0000_2000;
    bus.s_req_tdata[32 +: 32] = 32'h0000_f000;
    bus.s_req_tvalid = 4'b0110;
    #1;
    total++; if (bus.s_req_tready !== 4'b0010) begin bad++; $display("FAIL stall_other_grant got=%b exp=0010", bus.s_req_tready); end
    step();
    bus.s_req_tvalid = 4'b0100;
    seen1 = 1'b0;
    for (int c = 0; c < 6; c++) begin
      total++; if (bus.s_req_tready[2] !== 1'b0 || bus.m_rsp_tdata[64 +: 32] !== exp_fn(32'h1000))
        begin bad++; $display("FAIL stall_blocked cyc=%0d ready=%b data=%h exp=0/%h", c, bus.s_req_tready[2], bus.m_rsp_tdata[64 +: 32], exp_fn(32'h1000)); end
      if (bus.m_rsp_tvalid[1]) begin
        seen1 = 1'b1;
        total++; if (bus.m_rsp_tdata[32 +: 32] !== exp_fn(32'hf000))
          begin bad++; $display("FAIL stall_other_rsp got=%h exp=%h", bus.m_rsp_tdata[32 +: 32], exp_fn(32'hf000)); end
      end
      step();
    end
    total++; if (!seen1) begin bad++; $display("FAIL stall_other_rsp_missing got=0 exp=1"); end
    bus.m_rsp_tready = 4'hf;
    #1;
    total++; if (bus.s_req_tready !== 4'b0000) begin bad++; $display("FAIL stall_same_cycle got=%b exp=0000", bus.s_req_tready); end
    step();
    total++; if (bus.s_req_tready !== 4'b0100 || bus.m_rsp_tvalid[2] !== 1'b0)
      begin bad++; $display("FAIL stall_next_cycle ready=%b rsp_valid=%b exp=0100/0", bus.s_req_tready, bus.m_rsp_tvalid[2]); end
    step();
    bus.s_req_tvalid = '0;
    n = 0;
    while (!bus.m_rsp_tvalid[2] && n < 12) begin step(); n++; end
    total++; if (bus.m_rsp_tdata[64 +: 32] !== exp_fn(32'h2000) || bus.m_rsp_tvalid[2] !== 1'b1)
      begin bad++; $display("FAIL stall_second_rsp got=%h exp=%h", bus.m_rsp_tdata[64 +: 32], exp_fn(32'h2000)); end
    repeat (2) step();
  endtask

  task automatic test_backpressure();
    bit seen0, seen1;
    exp_ready = 1'b0;
    bus.s_req_tdata[0  +: 32] = 32'h0000_1000;
    bus.s_req_tdata[32 +: 32] = 32'h0000_2000;
    bus.s_req_tvalid = 4'b0011;
    #1;
    total++; if (bus.s_req_tready !== 4'b0001) begin bad++; $display("FAIL bp_first_grant got=%b exp=0001", bus.s_req_tready); end
    step();
    bus.s_req_tvalid = 4'b0010;
    for (int c = 0; c < 4; c++) begin
      total++; if (bus.s_req_tready !== 4'b0000 || bus.m_exp_tvalid !== 1'b1 || bus.m_exp_tdata !== 32'h1000)
        begin bad++; $display("FAIL bp_hold cyc=%0d ready=%b tvalid=%b data=%h exp=0000/1/00001000", c, bus.s_req_tready, bus.m_exp_tvalid, bus.m_exp_tdata); end
      step();
    end
    exp_ready = 1'b1;
    #1;
    total++; if (bus.s_req_tready !== 4'b0010) begin bad++; $display("FAIL bp_drain_grant got=%b exp=0010", bus.s_req_tready); end
    step();
    bus.s_req_tvalid = '0;
    total++; if (bus.m_exp_tdata !== 32'h2000) begin bad++; $display("FAIL bp_second_issue got=%h exp=00002000", bus.m_exp_tdata); end
    seen0 = 1'b0; seen1 = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (bus.m_rsp_tvalid[0]) begin
        seen0 = 1'b1;
        total++; if (bus.m_rsp_tdata[0 +: 32] !== exp_fn(32'h1000)) begin bad++; $display("FAIL bp_rsp0 got=%h exp=%h", bus.m_rsp_tdata[0 +: 32], exp_fn(32'h1000)); end
      end
      if (bus.m_rsp_tvalid[1]) begin
        seen1 = 1'b1;
        total++; if (bus.m_rsp_tdata[32 +: 32] !== exp_fn(32'h2000)) begin bad++; $display("FAIL bp_rsp1 got=%h exp=%h", bus.m_rsp_tdata[32 +: 32], exp_fn(32'h2000)); end
      end
    end
    total++; if (!(seen0 && seen1)) begin bad++; $display("FAIL bp_rsp_missing got=%b%b exp=11", seen0, seen1); end
  endtask

  task automatic test_orphan();
    total++; if (inflight !== 4'd0) begin bad++; $display("FAIL orphan_pre_inflight got=%0d exp=0", inflight); end
    orphan_pulse = 1'b1;
    step();
    orphan_pulse = 1'b0;
    for (int c = 0; c < 4; c++) begin
      total++; if (err_orphan !== 1'b1 || bus.m_rsp_tvalid !== 4'h0 || inflight !== 4'd0)
        begin bad++; $display("FAIL orphan cyc=%0d err=%b rsp_valid=%b inflight=%0d exp=1/0000/0", c, err_orphan, bus.m_rsp_tvalid, inflight); end
      step();
    end
  endtask

  task automatic test_reset_midstream();
    int n;
    bus.s_req_tdata[0  +: 32] = 32'h0000_0800;
    bus.s_req_tdata[32 +: 32] = 32'h0000_1800;
    bus.s_req_tdata[64 +: 32] = 32'h0000_2800;
    bus.s_req_tvalid = 4'b0111;
    for (int c = 0; c < 3; c++) begin
      #1;
      bus.s_req_tvalid = bus.s_req_tvalid;
      step();
      bus.s_req_tvalid = bus.s_req_tvalid & ~(4'b0111 & ~{1'b0, dut.credit_busy[2:0] ^ dut.credit_busy[2:0]} & 4'b0000);
    end
    bus.s_req_tvalid = '0;
    total++; if (inflight !== 4'd3) begin bad++; $display("FAIL mid_inflight got=%0d exp=3", inflight); end
    #2;
    aresetn = 1'b0;
    bus.s_req_tvalid = 4'hf;
    #1;
    total++; if (bus.s_req_tready !== 4'h0 || bus.m_exp_tvalid !== 1'b0 || bus.m_rsp_tvalid !== 4'h0 || bus.s_exp_tready !== 1'b0)
      begin bad++; $display("FAIL mid_reset_outputs ready=%b exp_v=%b rsp_v=%b exp_rdy=%b exp=0/0/0/0", bus.s_req_tready, bus.m_exp_tvalid, bus.m_rsp_tvalid, bus.s_exp_tready); end
    total++; if (inflight !== 4'd0 || err_orphan !== 1'b0 || dbg_last_grant !== 3'd3)
      begin bad++; $display("FAIL mid_reset_state inflight=%0d err=%b last=%0d exp=0/0/3", inflight, err_orphan, dbg_last_grant); end
    repeat (2) step();
    aresetn = 1'b1;
    #1;
    total++; if (bus.s_req_tready !== 4'b0001) begin bad++; $display("FAIL mid_first_grant got=%b exp=0001", bus.s_req_tready); end
    step();
    bus.s_req_tvalid = '0;
    total++; if (bus.m_exp_tdata !== 32'h0800 || dbg_last_grant !== 3'd0)
      begin bad++; $display("FAIL mid_issue data=%h last=%0d exp=00000800/0", bus.m_exp_tdata, dbg_last_grant); end
    n = 0;
    while (!bus.m_rsp_tvalid[0] && n < 12) begin step(); n++; end
    total++; if (bus.m_rsp_tvalid[0] !== 1'b1 || bus.m_rsp_tdata[0 +: 32] !== exp_fn(32'h0800) || err_orphan !== 1'b0)
      begin bad++; $display("FAIL mid_rsp data=%h err=%b exp=%h/0", bus.m_rsp_tdata[0 +: 32], err_orphan, exp_fn(32'h0800)); end
    repeat (2) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_credit_stall();
    test_backpressure();
    test_orphan();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
